// File: rtl/tnkiiicore_front_pkg.sv
// Shared types and constants for the front (sprite) line-buffer writer.
// Covers the scan states, the sprite attribute layout and the pixel format.
package tnkiiicore_front_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ATTR,
        CHECK,
        ROMRD,
        LOAD,
        PIX,
        NEXT
    } state_t;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] tile;
        logic       hflip;
        logic       x8;
        logic       y8;
        logic [4:0] color;
        logic [7:0] x;
    } spr_attr_t;

    localparam logic [7:0] FD_TRANSP = 8'hFF;
    localparam int         PIX_W     = 3;
    localparam int         ROW_PIX   = 16;
    localparam int         ROW_BITS  = PIX_W * ROW_PIX;

    // Sprite-relative row; the 9-bit wrap lets sprites straddle line 0.
    function automatic logic [8:0] spr_row(input logic [8:0] vpos, input logic [8:0] ypos);
        return vpos - ypos;
    endfunction

endpackage

// File: rtl/tnkiiicore_front_pixel_shifter.sv
// Holds one 16-pixel graphics row and presents it pixel by pixel, optionally mirrored.
module tnkiiicore_front_pixel_shifter
    import tnkiiicore_front_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_hflip,
    input  logic [ROW_BITS-1:0] i_data,
    input  logic                i_shift,
    output logic [PIX_W-1:0]    o_pix,
    output logic                o_done
);

    logic [ROW_BITS-1:0] w_rev;
    logic [ROW_BITS-1:0] w_load_data;
    logic [ROW_BITS-1:0] r_data;
    logic [3:0]          r_cnt;
    logic                r_done;

    genvar gi;
    generate
        for (gi = 0; gi < ROW_PIX; gi++) begin : g_rev
            assign w_rev[gi*PIX_W +: PIX_W] = i_data[(ROW_PIX-1-gi)*PIX_W +: PIX_W];
        end
    endgenerate

    assign w_load_data = i_hflip ? w_rev : i_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_load) begin
            r_data <= w_load_data;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_shift && !r_done) begin
            r_data <= {{PIX_W{1'b0}}, r_data[ROW_BITS-1:PIX_W]};
            r_cnt  <= r_cnt + 4'd1;
            if (r_cnt == 4'(ROW_PIX-1)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_pix  = r_data[PIX_W-1:0];
    assign o_done = r_done;

endmodule

// File: rtl/tnkiiicore_front_line_writer.sv
// Front sprite line-buffer producer: scans attribute RAM for the next line,
// fetches each hit's graphics row and streams a start-X load plus 16 pixels.
module tnkiiicore_front_line_writer
    import tnkiiicore_front_pkg::*;
#(
    parameter int NUM_SPR = 64,
    parameter int SPR_H   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CK0,
    input  logic        LT,
    input  logic [8:0]  VPOS,
    output logic [7:0]  SPR_A,
    input  logic [7:0]  SPR_D,
    output logic [11:0] ROM_A,
    output logic        ROM_REQ,
    input  logic [47:0] ROM_D,
    input  logic        ROM_ACK,
    output logic [7:0]  FD,
    output logic        FCK,
    output logic        LD,
    output logic [8:0]  FL_Y,
    output logic        BUSY
);

    state_t     r_state, w_state_next;
    logic       r_lt;
    logic [5:0] r_slot, w_slot_next;
    logic [2:0] r_acnt, w_acnt_next;
    spr_attr_t  r_attr, w_attr_next;
    logic [7:0] r_spr_a, w_spr_a_next;
    logic [11:0] r_rom_a, w_rom_a_next;
    logic       r_rom_req, w_rom_req_next;
    logic [7:0] r_fd, w_fd_next;
    logic       r_fck, w_fck_next;
    logic       r_ld, w_ld_next;
    logic [8:0] r_fl_y, w_fl_y_next;
    logic       r_busy, w_busy_next;

    logic             w_lt_rise;
    logic [8:0]       w_row;
    logic             w_hit;
    logic             w_sh_load;
    logic             w_sh_shift;
    logic [PIX_W-1:0] w_pix;
    logic             w_pix_done;

    assign w_lt_rise = LT & ~r_lt;
    assign w_row     = spr_row(VPOS, {r_attr.y8, r_attr.y});
    assign w_hit     = (w_row < 9'(SPR_H));

    tnkiiicore_front_pixel_shifter u_shifter (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_sh_load),
        .i_hflip (r_attr.hflip),
        .i_data  (ROM_D),
        .i_shift (w_sh_shift),
        .o_pix   (w_pix),
        .o_done  (w_pix_done)
    );

    always_comb begin
        w_state_next   = r_state;
        w_slot_next    = r_slot;
        w_acnt_next    = r_acnt;
        w_attr_next    = r_attr;
        w_spr_a_next   = r_spr_a;
        w_rom_a_next   = r_rom_a;
        w_rom_req_next = r_rom_req;
        w_fd_next      = r_fd;
        w_fck_next     = 1'b0;
        w_ld_next      = 1'b1;
        w_fl_y_next    = r_fl_y;
        w_busy_next    = r_busy;
        w_sh_load      = 1'b0;
        w_sh_shift     = 1'b0;

        // A line toggle always (re)starts the scan, aborting any work in flight.
        if (w_lt_rise) begin
            w_state_next   = ATTR;
            w_slot_next    = '0;
            w_acnt_next    = '0;
            w_spr_a_next   = '0;
            w_rom_req_next = 1'b0;
            w_fd_next      = FD_TRANSP;
            w_busy_next    = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                end
                ATTR: begin
                    // Address k goes out in cycle k; its data is captured in cycle k+1.
                    case (r_acnt)
                        3'd1: w_attr_next.y = SPR_D;
                        3'd2: w_attr_next.tile = SPR_D;
                        3'd3: {w_attr_next.hflip, w_attr_next.x8,
                               w_attr_next.y8, w_attr_next.color} = SPR_D;
                        3'd4: w_attr_next.x = SPR_D;
                        default: begin
                        end
                    endcase
                    if (r_acnt < 3'd3) begin
                        w_spr_a_next = {r_slot, r_acnt[1:0] + 2'd1};
                    end
                    if (r_acnt == 3'd4) begin
                        w_state_next = CHECK;
                    end else begin
                        w_acnt_next = r_acnt + 3'd1;
                    end
                end
                CHECK: begin
                    if (w_hit) begin
                        w_rom_a_next   = {r_attr.tile, w_row[3:0]};
                        w_rom_req_next = 1'b1;
                        w_state_next   = ROMRD;
                    end else begin
                        w_state_next = NEXT;
                    end
                end
                ROMRD: begin
                    if (ROM_ACK) begin
                        w_sh_load      = 1'b1;
                        w_rom_req_next = 1'b0;
                        w_state_next   = LOAD;
                    end
                end
                LOAD: begin
                    // The load strobe lasts one clk; pixels start on the following CK0s.
                    if (r_fck) begin
                        w_state_next = PIX;
                    end else if (CK0) begin
                        w_fck_next  = 1'b1;
                        w_ld_next   = 1'b0;
                        w_fl_y_next = {r_attr.x8, r_attr.x};
                        w_fd_next   = FD_TRANSP;
                    end
                end
                PIX: begin
                    if (w_pix_done) begin
                        w_fd_next    = FD_TRANSP;
                        w_state_next = NEXT;
                    end else if (CK0) begin
                        w_fd_next  = {r_attr.color, w_pix};
                        w_sh_shift = 1'b1;
                    end
                end
                NEXT: begin
                    if (r_slot == 6'(NUM_SPR-1)) begin
                        w_busy_next  = 1'b0;
                        w_state_next = IDLE;
                    end else begin
                        w_slot_next  = r_slot + 6'd1;
                        w_acnt_next  = '0;
                        w_spr_a_next = {r_slot + 6'd1, 2'd0};
                        w_state_next = ATTR;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lt      <= 1'b0;
            r_slot    <= '0;
            r_acnt    <= '0;
            r_attr    <= '0;
            r_spr_a   <= '0;
            r_rom_a   <= '0;
            r_rom_req <= 1'b0;
            r_fd      <= FD_TRANSP;
            r_fck     <= 1'b0;
            r_ld      <= 1'b1;
            r_fl_y    <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_lt      <= LT;
            r_slot    <= w_slot_next;
            r_acnt    <= w_acnt_next;
            r_attr    <= w_attr_next;
            r_spr_a   <= w_spr_a_next;
            r_rom_a   <= w_rom_a_next;
            r_rom_req <= w_rom_req_next;
            r_fd      <= w_fd_next;
            r_fck     <= w_fck_next;
            r_ld      <= w_ld_next;
            r_fl_y    <= w_fl_y_next;
            r_busy    <= w_busy_next;
        end
    end

    assign SPR_A   = r_spr_a;
    assign ROM_A   = r_rom_a;
    assign ROM_REQ = r_rom_req;
    assign FD      = r_fd;
    assign FCK     = r_fck;
    assign LD      = r_ld;
    assign FL_Y    = r_fl_y;
    assign BUSY    = r_busy;

endmodule

// File: tb/tb_tnkiiicore_front_line_writer.sv
// Bench for the front line writer: table of single-sprite scans plus abort/reset sequences,
// with a scoreboard of expected load/pixel events.
module tb_tnkiiicore_front_line_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        CK0;
    logic        LT;
    logic [8:0]  VPOS;
    logic [7:0]  SPR_A;
    logic [7:0]  SPR_D;
    logic [11:0] ROM_A;
    logic        ROM_REQ;
    logic [47:0] ROM_D;
    logic        ROM_ACK;
    logic [7:0]  FD;
    logic        FCK;
    logic        LD;
    logic [8:0]  FL_Y;
    logic        BUSY;

    always #5 clk = ~clk;

    tnkiiicore_front_line_writer dut (
        .clk     (clk),
        .rst     (rst),
        .CK0     (CK0),
        .LT      (LT),
        .VPOS    (VPOS),
        .SPR_A   (SPR_A),
        .SPR_D   (SPR_D),
        .ROM_A   (ROM_A),
        .ROM_REQ (ROM_REQ),
        .ROM_D   (ROM_D),
        .ROM_ACK (ROM_ACK),
        .FD      (FD),
        .FCK     (FCK),
        .LD      (LD),
        .FL_Y    (FL_Y),
        .BUSY    (BUSY)
    );

    typedef struct packed {
        logic       is_load;
        logic [8:0] val;
    } ev_t;

    typedef struct {
        logic [8:0]  y9;
        logic [7:0]  tile;
        logic        hflip;
        logic [8:0]  x9;
        logic [4:0]  color;
        logic [8:0]  vpos;
        logic [47:0] rom;
        int          ack_dly;
        logic        exp_hit;
        logic [11:0] exp_rom_a;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         req_rises = 0;
    logic       req_prev = 1'b0;
    logic [7:0] spr_a_prev = 8'd0;
    logic [7:0] spr_mem [0:255];
    ev_t        sb_q [$];
    vec_t       vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic observe(input logic is_load, input logic [8:0] val);
        ev_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got load=%0d val=0x%0h, required no event", is_load, val);
        end else begin
            e = sb_q.pop_front();
            if (e.is_load !== is_load || e.val !== val) begin
                errors++;
                $display("FAIL sb_event: got load=%0d val=0x%0h, required load=%0d val=0x%0h",
                         is_load, val, e.is_load, e.val);
            end
        end
    endtask

    // One clock: sprite RAM (1-clk latency), event monitor, then CK0 for the next edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        SPR_D      = spr_mem[spr_a_prev];
        spr_a_prev = SPR_A;
        if (ROM_REQ === 1'b1 && !req_prev) req_rises++;
        req_prev = (ROM_REQ === 1'b1);
        if (FCK === 1'b1 && LD === 1'b0) observe(1'b1, FL_Y);
        else if (CK0 && FD !== 8'hFF && rst === 1'b0) observe(1'b0, {1'b0, FD});
        CK0 = (cyc % 4 == 0);
    endtask

    function automatic logic [47:0] pat(input int a, input int b);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*3 +: 3] = 3'((a * i + b) % 8);
        return r;
    endfunction

    task automatic fill_bg();
        for (int s = 0; s < 64; s++) begin
            spr_mem[s*4+0] = 8'hF0;
            spr_mem[s*4+1] = 8'h00;
            spr_mem[s*4+2] = 8'h00;
            spr_mem[s*4+3] = 8'h00;
        end
    endtask

    task automatic set_slot(input int s, input logic [8:0] y9, input logic [7:0] tile,
                            input logic hflip, input logic [8:0] x9, input logic [4:0] color);
        spr_mem[s*4+0] = y9[7:0];
        spr_mem[s*4+1] = tile;
        spr_mem[s*4+2] = {hflip, x9[8], y9[8], color};
        spr_mem[s*4+3] = x9[7:0];
    endtask

    task automatic push_sprite(input logic [8:0] x9, input logic [4:0] color,
                               input logic hflip, input logic [47:0] rd);
        ev_t e;
        int  src;
        e.is_load = 1'b1;
        e.val     = x9;
        sb_q.push_back(e);
        for (int i = 0; i < 16; i++) begin
            src       = hflip ? 15 - i : i;
            e.is_load = 1'b0;
            e.val     = {1'b0, color, rd[src*3 +: 3]};
            sb_q.push_back(e);
        end
    endtask

    task automatic pulse_lt();
        LT = 1'b1;
        tick();
        LT = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (ROM_REQ !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk(name, {63'd0, ROM_REQ === 1'b1}, 64'd1);
    endtask

    task automatic ack_rom(input logic [47:0] rd);
        ROM_D   = rd;
        ROM_ACK = 1'b1;
        tick();
        ROM_ACK = 1'b0;
        ROM_D   = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (BUSY !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        chk(name, {63'd0, BUSY === 1'b0}, 64'd1);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        logic stable;
        logic got_load;
        v = vecs[idx];
        fill_bg();
        set_slot(0, v.y9, v.tile, v.hflip, v.x9, v.color);
        VPOS = v.vpos;
        if (v.exp_hit) push_sprite(v.x9, v.color, v.hflip, v.rom);
        req_rises = 0;
        pulse_lt();
        if (v.exp_hit) begin
            wait_req("rom_req_rise");
            chk("rom_a", 64'(ROM_A), 64'(v.exp_rom_a));
            stable = 1'b1;
            for (int d = 0; d < v.ack_dly; d++) begin
                tick();
                if (ROM_REQ !== 1'b1 || ROM_A !== v.exp_rom_a || FCK !== 1'b0) stable = 1'b0;
            end
            chk("rom_stall_stable", {63'd0, stable}, 64'd1);
            ack_rom(v.rom);
            chk("rom_req_drop", {63'd0, ROM_REQ}, 64'd0);
            got_load = 1'b0;
            for (int k = 0; k < 6 && !got_load; k++) begin
                tick();
                if (FCK === 1'b1 && LD === 1'b0) got_load = 1'b1;
            end
            chk("load_after_ack", {63'd0, got_load}, 64'd1);
        end
        wait_idle("scan_done");
        chk("rom_req_count", 64'(req_rises), {63'd0, v.exp_hit});
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("vec %0d: vpos=0x%0h hit=%0d rom_req=%0d checks=%0d errors=%0d",
                 idx, v.vpos, v.exp_hit, req_rises, checks, errors);
    endtask

    initial begin
        rst     = 1'b1;
        CK0     = 1'b0;
        LT      = 1'b0;
        VPOS    = '0;
        SPR_D   = '0;
        ROM_D   = '0;
        ROM_ACK = 1'b0;
        fill_bg();

        vecs[0] = '{9'h020, 8'h05, 1'b0, 9'h040, 5'h03, 9'h025, pat(1, 0), 200, 1'b1, 12'h055};
        vecs[1] = '{9'h020, 8'h05, 1'b1, 9'h040, 5'h03, 9'h025, pat(3, 1), 3,   1'b1, 12'h055};
        vecs[2] = '{9'h1F8, 8'h7A, 1'b0, 9'h1F5, 5'h11, 9'h002, pat(5, 2), 5,   1'b1, 12'h7AA};
        vecs[3] = '{9'h1F8, 8'h7A, 1'b0, 9'h1F5, 5'h11, 9'h1F0, pat(5, 2), 5,   1'b0, 12'h000};
        vecs[4] = '{9'h010, 8'hC3, 1'b0, 9'h0AB, 5'h1E, 9'h01F, pat(7, 3), 1,   1'b1, 12'hC3F};
        vecs[5] = '{9'h010, 8'hC3, 1'b0, 9'h0AB, 5'h1E, 9'h020, pat(7, 3), 1,   1'b0, 12'h000};

        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        tick();
        chk("reset_fd", 64'(FD), 64'hFF);
        chk("reset_fck", {63'd0, FCK}, 64'd0);
        chk("reset_ld", {63'd0, LD}, 64'd1);
        chk("reset_fl_y", 64'(FL_Y), 64'd0);
        chk("reset_rom_req", {63'd0, ROM_REQ}, 64'd0);
        chk("reset_spr_a", 64'(SPR_A), 64'd0);
        chk("reset_busy", {63'd0, BUSY}, 64'd0);
        $display("reset: fd=0x%0h ld=%0d busy=%0d", FD, LD, BUSY);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Line toggle mid-pixel-stream on slot 3, then a stale ACK during the re-scan.
        fill_bg();
        set_slot(3, 9'h020, 8'h05, 1'b0, 9'h040, 5'h03);
        VPOS = 9'h025;
        push_sprite(9'h040, 5'h03, 1'b0, pat(1, 0));
        pulse_lt();
        wait_req("abort_req_rise");
        chk("abort_rom_a", 64'(ROM_A), 64'h055);
        ack_rom(pat(1, 0));
        for (int n = 0; n < 200 && sb_q.size() > 12; n++) tick();
        chk("abort_in_pix", 64'(sb_q.size()), 64'd12);
        LT = 1'b1;
        tick();
        chk("abort_fd", 64'(FD), 64'hFF);
        chk("abort_spr_a", 64'(SPR_A), 64'd0);
        chk("abort_busy", {63'd0, BUSY}, 64'd1);
        chk("abort_ld", {63'd0, LD}, 64'd1);
        LT = 1'b0;
        sb_q.delete();
        push_sprite(9'h040, 5'h03, 1'b0, pat(1, 0));
        tick();
        ack_rom(48'h0);
        req_rises = 0;
        wait_req("rescan_req_rise");
        chk("rescan_rom_a", 64'(ROM_A), 64'h055);
        tick();
        ack_rom(pat(1, 0));
        wait_idle("rescan_done");
        chk("rescan_req_count", 64'(req_rises), 64'd1);
        chk("rescan_sb_drained", 64'(sb_q.size()), 64'd0);
        $display("abort: checks=%0d errors=%0d", checks, errors);

        // Reset while a ROM request is pending, then an ACK while idle.
        fill_bg();
        set_slot(0, 9'h020, 8'h05, 1'b0, 9'h040, 5'h03);
        VPOS = 9'h025;
        pulse_lt();
        wait_req("rst_req_rise");
        rst = 1'b1;
        tick();
        chk("rst_rom_req", {63'd0, ROM_REQ}, 64'd0);
        chk("rst_busy", {63'd0, BUSY}, 64'd0);
        chk("rst_fd", 64'(FD), 64'hFF);
        chk("rst_ld", {63'd0, LD}, 64'd1);
        chk("rst_fl_y", 64'(FL_Y), 64'd0);
        rst = 1'b0;
        tick();
        ack_rom(pat(1, 0));
        for (int n = 0; n < 20; n++) tick();
        chk("idle_ack_busy", {63'd0, BUSY}, 64'd0);
        chk("idle_ack_rom_req", {63'd0, ROM_REQ}, 64'd0);
        $display("reset-mid-romrd: checks=%0d errors=%0d", checks, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tnkiiicore_front_line_writer.md
Name: tnkiiicore_front_line_writer

Overview:
- Producer side of the front (sprite) ping-pong line buffer.
- Each line toggle (LT), it scans sprite attribute RAM for sprites intersecting the next line (VPOS).
- For each hit it fetches one 16-pixel 3bpp graphics row, then emits a start-X load followed by 16 pixel writes (FD) on CK0 enables.
- Transparent pixels are encoded FD[2:0]=3'b111, so the buffer inhibits those writes.

Parameters:
- NUM_SPR, 64, sprite slots scanned per line (4 attribute bytes each).
- SPR_H, 16, sprite height in lines (power of two).

Ports:
- clk  in  1  master clock.
- rst  in  1  synchronous, active-high reset.
- CK0  in  1  pixel write clock enable, one-clk pulse.
- LT  in  1  line toggle; rising edge starts a new scan.
- VPOS  in  9  line number being prepared.
- SPR_A  out  8  sprite RAM byte address {slot[5:0], byte[1:0]}.
- SPR_D  in  8  sprite RAM data, valid 1 clk after SPR_A.
- ROM_A  out  12  graphics row address {tile[7:0], row[3:0]}.
- ROM_REQ  out  1  ROM request level.
- ROM_D  in  48  16 px x 3 bit, pixel0 in [2:0].
- ROM_ACK  in  1  one-clk pulse, ROM_D valid.
- FD  out  8  {color[4:0], pix[2:0]}.
- FCK  out  1  load strobe; buffer loads when FCK=1 and LD=0.
- LD  out  1  load, active low.
- FL_Y  out  9  start X loaded into the buffer write counter.
- BUSY  out  1  scan in progress.

Behaviour:
- Reset values: FD=8'hFF, FCK=0, LD=1, FL_Y=0, ROM_REQ=0, SPR_A=0, BUSY=0; state IDLE.
- Attribute bytes:
  - b0 = Y[7:0].
  - b1 = tile[7:0].
  - b2 = {hflip, X8, Y8, color[4:0]}.
  - b3 = X[7:0].
- Row calculation: row = VPOS - {Y8,Y} modulo 512 (9-bit wrap). Sprite is a hit iff row < SPR_H.
- States:
  - IDLE: waits for LT rising edge (LT registered one clk). On edge: slot=0, BUSY=1, go to ATTR.
  - ATTR: issues byte addresses 0..3 on consecutive clks; captures each byte 1 clk later. Total 5 clks, then CHECK.
  - CHECK (1 clk): hit -> ROMRD; miss -> NEXT.
  - ROMRD: holds ROM_REQ=1 with ROM_A stable until ROM_ACK. Captures ROM_D, reversed if hflip. Drops ROM_REQ the same clk, then LOAD.
  - LOAD: waits for CK0. On that CK0 clk drives FCK=1, LD=0, FL_Y={X8,X}, FD=8'hFF. Next clk FCK=0, LD=1; go to PIX.
  - PIX: on each of the next 16 CK0 clks drives FD={color, pixel i} for i=0..15. FD returns to 8'hFF on the clk after the 16th CK0. Then NEXT.
  - NEXT: slot==NUM_SPR-1 -> IDLE with BUSY=0; else slot+1 -> ATTR.
- Outputs change only on CK0 clks, except the registered return to idle levels.
- Pixel FD is held between CK0 pulses.
- LT edge while BUSY: abort immediately. ROM_REQ drops, FD=8'hFF, FCK=0, LD=1. Restart at slot 0 on the next clk; a pending ROM_ACK is ignored.
- ROM_ACK outside ROMRD is ignored.
- Pixel value 3'b111 from ROM is emitted unchanged; the buffer treats it as transparent.
- X wrap (X > 511-15) is handled by the buffer counter; the writer does no clipping.
- rst at any time returns to IDLE and the reset values on the next clk.

Decomposition:
- Package tnkiiicore_front_pkg:
  - state enum: IDLE, ATTR, CHECK, ROMRD, LOAD, PIX, NEXT.
  - spr_attr_t packed struct.
  - FD_TRANSP = 8'hFF.
  - PIX_W = 3.
- Sub-module tnkiiicore_front_pixel_shifter: 48-bit load with optional hflip, shifts 3 bits per CK0, 4-bit pixel counter, done flag.

Test Plan:
- Slot 0 = {Y=0x20, tile=0x05, b2=0x03, X=0x40}, VPOS=0x025, other slots Y=0xF0 -> ROM_A=0x055; one load with FL_Y=0x040; 16 FD values 0x18|pix; no other loads.
- Same sprite with hflip=1 and ROM_D pixel0=1, pixel15=6 -> first FD=0x1E, last FD=0x19.
- Y8=1, Y=0xF8 (Y=504), VPOS=2 -> row=10, hit. VPOS=0x1F0 -> row wraps to 0x1F8, miss, no ROM_REQ.
- Hold ROM_ACK off for 200 clks -> ROM_REQ and ROM_A held stable, no FCK. ACK pulse -> LOAD on the next CK0.
- LT edge during PIX of slot 3 -> FD=0xFF next clk, then SPR_A=0 re-scan; the stale ROM_ACK injected afterwards is ignored.
- rst mid-ROMRD -> ROM_REQ=0, BUSY=0, FD=0xFF, LD=1 on the following clk.
